// File: rtl/gdp_sum_unit.sv
//------------------------------------------------------------------------------
// Module   : gdp_sum_unit
// Purpose  : GDP data path (regfile/ALU/shifter) with an autonomous n+..+1 summer
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gdp_sum_unit #(
  parameter  int WIDTH = 8,
  parameter  int REGS  = 4,
  localparam int AW    = $clog2(REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] n_in,
  input  logic             start,
  input  logic             manual_en,
  input  logic             input_enable_mux,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic             RAE,
  input  logic [AW-1:0]    RAA,
  input  logic             RBE,
  input  logic [AW-1:0]    RBA,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       shift_op,
  input  logic             output_enable_buf,
  output logic [WIDTH-1:0] run_sum,
  output logic             n_is_0,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [AW-1:0] c_R_SUM = AW'(0);
  localparam logic [AW-1:0] c_R_CNT = AW'(1);

  localparam logic [2:0] c_ALU_PASS = 3'b000;
  localparam logic [2:0] c_ALU_AND  = 3'b001;
  localparam logic [2:0] c_ALU_OR   = 3'b010;
  localparam logic [2:0] c_ALU_NOT  = 3'b011;
  localparam logic [2:0] c_ALU_ADD  = 3'b100;
  localparam logic [2:0] c_ALU_SUB  = 3'b101;
  localparam logic [2:0] c_ALU_INC  = 3'b110;
  localparam logic [2:0] c_ALU_DEC  = 3'b111;

  localparam logic [1:0] c_SH_PASS = 2'b00;
  localparam logic [1:0] c_SH_SHL  = 2'b01;
  localparam logic [1:0] c_SH_SHR  = 2'b10;
  localparam logic [1:0] c_SH_ROR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_TEST = 3'd2,
    S_ADD  = 3'd3,
    S_DEC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_rf [REGS];
  logic             r_busy;
  logic             r_overflow;

  // Control word produced by the sequencer
  logic             w_f_we;
  logic [AW-1:0]    w_f_wa;
  logic             w_f_mux;
  logic             w_f_rae;
  logic [AW-1:0]    w_f_raa;
  logic             w_f_rbe;
  logic [AW-1:0]    w_f_rba;
  logic [2:0]       w_f_alu;
  logic [1:0]       w_f_shift;
  logic             w_f_buf;

  // Control word actually steering the datapath
  logic             w_fsm_sel;
  logic             w_man_sel;
  logic             w_we;
  logic [AW-1:0]    w_wa;
  logic             w_mux;
  logic             w_rae;
  logic [AW-1:0]    w_raa;
  logic             w_rbe;
  logic [AW-1:0]    w_rba;
  logic [2:0]       w_alu_op;
  logic [1:0]       w_shift_op;
  logic             w_buf;

  logic [WIDTH-1:0] w_port_a;
  logic [WIDTH-1:0] w_port_b;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_alu_out;
  logic [WIDTH-1:0] w_shift_out;
  logic [WIDTH-1:0] w_wdata;

  //----------------------------------------------------------------------------
  // Sequencer
  //----------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_f_we       = 1'b0;
    w_f_wa       = '0;
    w_f_mux      = 1'b0;
    w_f_rae      = 1'b0;
    w_f_raa      = '0;
    w_f_rbe      = 1'b0;
    w_f_rba      = '0;
    w_f_alu      = c_ALU_PASS;
    w_f_shift    = c_SH_PASS;
    w_f_buf      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_f_we       = 1'b1;
          w_f_wa       = c_R_CNT;
          w_f_mux      = 1'b1;
          w_next_state = S_CLR;
        end
      end
      S_CLR: begin
        w_f_rae      = 1'b1;
        w_f_raa      = c_R_SUM;
        w_f_rbe      = 1'b1;
        w_f_rba      = c_R_SUM;
        w_f_alu      = c_ALU_SUB;
        w_f_we       = 1'b1;
        w_f_wa       = c_R_SUM;
        w_next_state = S_TEST;
      end
      S_TEST: begin
        w_f_rae      = 1'b1;
        w_f_raa      = c_R_CNT;
        // Port A carries r1 here, so the zero test reads the counter directly
        w_next_state = (r_rf[c_R_CNT] == '0) ? S_DONE : S_ADD;
      end
      S_ADD: begin
        w_f_rae      = 1'b1;
        w_f_raa      = c_R_SUM;
        w_f_rbe      = 1'b1;
        w_f_rba      = c_R_CNT;
        w_f_alu      = c_ALU_ADD;
        w_f_we       = 1'b1;
        w_f_wa       = c_R_SUM;
        w_next_state = S_DEC;
      end
      S_DEC: begin
        w_f_rae      = 1'b1;
        w_f_raa      = c_R_CNT;
        w_f_alu      = c_ALU_DEC;
        w_f_we       = 1'b1;
        w_f_wa       = c_R_CNT;
        w_next_state = S_TEST;
      end
      S_DONE: begin
        w_f_rae      = 1'b1;
        w_f_raa      = c_R_SUM;
        w_f_buf      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  //----------------------------------------------------------------------------
  // Control source selection
  //----------------------------------------------------------------------------
  assign w_fsm_sel = (r_state != S_IDLE) || start;
  assign w_man_sel = !w_fsm_sel && manual_en;

  always_comb begin
    w_we       = 1'b0;
    w_wa       = '0;
    w_mux      = 1'b0;
    w_rae      = 1'b0;
    w_raa      = '0;
    w_rbe      = 1'b0;
    w_rba      = '0;
    w_alu_op   = c_ALU_PASS;
    w_shift_op = c_SH_PASS;
    w_buf      = 1'b0;
    if (w_fsm_sel) begin
      w_we       = w_f_we;
      w_wa       = w_f_wa;
      w_mux      = w_f_mux;
      w_rae      = w_f_rae;
      w_raa      = w_f_raa;
      w_rbe      = w_f_rbe;
      w_rba      = w_f_rba;
      w_alu_op   = w_f_alu;
      w_shift_op = w_f_shift;
      w_buf      = w_f_buf;
    end else if (w_man_sel) begin
      w_we       = WE;
      w_wa       = WA;
      w_mux      = input_enable_mux;
      w_rae      = RAE;
      w_raa      = RAA;
      w_rbe      = RBE;
      w_rba      = RBA;
      w_alu_op   = alu_op;
      w_shift_op = shift_op;
      w_buf      = output_enable_buf;
    end
  end

  //----------------------------------------------------------------------------
  // Datapath
  //----------------------------------------------------------------------------
  assign w_port_a  = w_rae ? r_rf[w_raa] : '0;
  assign w_port_b  = w_rbe ? r_rf[w_rba] : '0;
  assign w_sum_ext = {1'b0, w_port_a} + {1'b0, w_port_b};

  always_comb begin
    w_alu_out = w_port_a;
    case (w_alu_op)
      c_ALU_PASS: w_alu_out = w_port_a;
      c_ALU_AND:  w_alu_out = w_port_a & w_port_b;
      c_ALU_OR:   w_alu_out = w_port_a | w_port_b;
      c_ALU_NOT:  w_alu_out = ~w_port_a;
      c_ALU_ADD:  w_alu_out = w_sum_ext[WIDTH-1:0];
      c_ALU_SUB:  w_alu_out = w_port_a - w_port_b;
      c_ALU_INC:  w_alu_out = w_port_a + WIDTH'(1);
      c_ALU_DEC:  w_alu_out = w_port_a - WIDTH'(1);
      default:    w_alu_out = w_port_a;
    endcase
  end

  always_comb begin
    w_shift_out = w_alu_out;
    case (w_shift_op)
      c_SH_PASS: w_shift_out = w_alu_out;
      c_SH_SHL:  w_shift_out = {w_alu_out[WIDTH-2:0], 1'b0};
      c_SH_SHR:  w_shift_out = {1'b0, w_alu_out[WIDTH-1:1]};
      c_SH_ROR:  w_shift_out = {w_alu_out[0], w_alu_out[WIDTH-1:1]};
      default:   w_shift_out = w_alu_out;
    endcase
  end

  assign w_wdata = w_mux ? n_in : w_shift_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_we) begin
      r_rf[w_wa] <= w_wdata;
    end
  end

  // Sticky carry from autonomous adds; a new accepted run starts clean
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_ADD) && w_sum_ext[WIDTH]) begin
      r_overflow <= 1'b1;
    end
  end

  assign run_sum  = w_buf ? w_shift_out : '0;
  assign n_is_0   = (w_port_a == '0);
  assign busy     = r_busy;
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: doc/gdp_sum_unit.md
# gdp_sum_unit

Parametrised general data path with a built-in summation controller. It keeps the manual control-word interface of the existing GDP data path: register file, ALU, shifter, input mux and output buffer. It adds a width/depth-generic register file, synchronous reset, an overflow flag, and an autonomous mode that computes n + (n-1) + … + 1 under a start/busy/done handshake. It sits between the HW4 top-level controller and the board I/O.

## Interface
- WIDTH, 8, data width in bits (≥2).
- REGS, 4, register-file depth (power of two, ≥2); AW = clog2(REGS) is derived, not overridable.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- n_in  in  WIDTH  external operand.
- start  in  1  launch autonomous sum; sampled in IDLE only.
- manual_en  in  1  manual control word drives the datapath; effective in IDLE with start=0.
- input_enable_mux  in  1  write data = n_in (1) or shifter result (0).
- WE, WA  in  1, AW  write enable and write address.
- RAE, RAA  in  1, AW  read port A enable and address.
- RBE, RBA  in  1, AW  read port B enable and address.
- alu_op  in  3  ALU operation.
- shift_op  in  2  shifter operation.
- output_enable_buf  in  1  drive run_sum.
- run_sum  out  WIDTH  shifter result when the buffer is enabled, else 0.
- n_is_0  out  1  port-A data == 0.
- busy  out  1  high from the start edge until DONE is left.
- done  out  1  one-cycle pulse; run_sum holds the final sum in that cycle.
- overflow  out  1  sticky carry-out of any autonomous ADD.

## Operation
- Register file: REGS×WIDTH. Reset clears all entries. Written on a rising edge when the effective write enable is 1.
- Read ports: A = RAE ? rf[RAA] : 0 and B = RBE ? rf[RBA] : 0. Both are combinational.
- ALU encodings (all modulo 2^WIDTH):
  - 000 A, 001 A&B, 010 A|B, 011 ~A
  - 100 A+B, 101 A−B, 110 A+1, 111 A−1
- Shifter encodings: 00 pass, 01 shl (0 fill), 10 logical shr, 11 rotate right by 1.
- Write data = effective mux ? n_in : shifter output.
- Effective control source:
  - FSM outputs when state ≠ IDLE, or when IDLE with start=1.
  - Manual ports when IDLE, start=0, manual_en=1.
  - Otherwise everything is disabled (no write, ports read 0, buffer off).
- FSM states: IDLE, CLR, TEST, ADD, DEC, DONE. Register r0 holds the sum; r1 holds the counter.
  - IDLE: on start=1, write r1←n_in, clear overflow, go to CLR.
  - CLR: r0←r0−r0 (ALU 101), go to TEST.
  - TEST: read r1 on port A. If n_is_0, go to DONE; else go to ADD.
  - ADD: r0←r0+r1. If the true sum ≥ 2^WIDTH, set overflow. Go to DEC.
  - DEC: r1←r1−1 (ALU 111), go to TEST.
  - DONE: port A = r0, ALU pass, buffer on, done=1, go to IDLE.
- start while busy is ignored. Manual inputs are ignored while busy.
- Overflow stays set until the next accepted start or reset. On overflow, run_sum is the sum modulo 2^WIDTH.
- After DONE, r0 keeps the sum and can be read manually.

## Timing
- Reset values:
  - run_sum 0 (buffer off).
  - n_is_0 1 (port A reads 0).
  - busy 0, done 0, overflow 0.
  - state IDLE, all registers 0.
- Reset mid-operation: on the next edge, everything returns to reset values. There is no partial result and no done pulse.
- Register writes take effect on the clock edge. Reads and outputs are combinational from the current state and registers.
- Autonomous latency: with start sampled at edge k, DONE is entered at edge k+2+3n.
  - done is high for exactly one cycle, then the unit is IDLE at edge k+3+3n.
  - n=0: done follows edge k+2, and run_sum = 0.
- busy is a registered Moore output: it rises after edge k and falls after the DONE cycle.
- n_in needs to be stable only at the start edge.
- start held high through DONE relaunches on the first IDLE cycle. Each accepted start is a fresh run.

## Test plan
- Reset, then idle for 5 cycles → run_sum=0, n_is_0=1, busy=0, done=0, overflow=0.
- Manual sequence, one control word per cycle:
  - r0←r0−r0, then r1←3 via the mux, then r0←r0+r1 with WE=1 → reading r0 with the buffer on gives run_sum=3.
  - Repeating the add with WE=0 leaves r0=3.
- Autonomous, WIDTH=8, n=3 → done pulses 11 edges after the start edge with run_sum=6 and overflow=0. n=0 → done after 2 edges with run_sum=0.
- Autonomous n=22 → run_sum=253, overflow=0. Autonomous n=23 → run_sum=20 (276 mod 256), overflow=1. The next start clears overflow.
- Robustness:
  - start pulsed during busy and manual WE toggling during busy → no effect on the result; sum stays 6 for n=3.
  - reset asserted mid-run → no done pulse; all outputs return to reset values.
- WIDTH=16, REGS=8, n=300 → run_sum=45150, done at start edge +902.
